// File: rtl/sar8b_logic.sv
// Successive-approximation controller for the 8-bit SAR ADC: sampling phase,
// binary-search trial/latch sequence and result publication.
module sar8b_logic #(
    parameter int NBIT       = 8,
    parameter int SAMPLE_CYC = 1
) (
    input  logic            CK,
    input  logic            RSTN,
    input  logic            EN,
    input  logic            CKS,
    input  logic            CMP,
    output logic            SAMPLE,
    output logic            CMPCK,
    output logic [NBIT-1:0] DAC,
    output logic [NBIT-1:0] DOUT,
    output logic            VALID,
    output logic            OVR,
    output logic            BUSY
);

    localparam int IW = (NBIT > 1) ? $clog2(NBIT) : 1;
    localparam int SW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
    localparam logic [IW-1:0] IDX_TOP   = IW'(NBIT - 1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(SAMPLE_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_TRIAL  = 3'd2,
        ST_LATCH  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            cks_q_r;
    logic            start_s;
    logic            ovr_hit_s;
    logic [NBIT-1:0] res_r;
    logic [NBIT-1:0] res_upd_s;
    logic [NBIT-1:0] dout_r;
    logic [IW-1:0]   idx_r;
    logic [SW-1:0]   scnt_r;
    logic            ovr_r;

    // Trial code: the bits already resolved plus the bit under test.
    function automatic logic [NBIT-1:0] trial_code(input logic [NBIT-1:0] res,
                                                   input logic [IW-1:0]   idx);
        logic [NBIT-1:0] t;
        t      = res;
        t[idx] = 1'b1;
        return t;
    endfunction

    // Start detection, overrun detection and the result with the current decision folded in.
    always_comb begin
        start_s   = CKS & ~cks_q_r & EN;
        ovr_hit_s = start_s & ((state_r == ST_SAMPLE) | (state_r == ST_TRIAL) |
                               (state_r == ST_LATCH));
        res_upd_s        = res_r;
        res_upd_s[idx_r] = CMP;
    end

    // Next-state logic; a low EN overrides everything and returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (!EN) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) state_nxt_s = ST_SAMPLE;
                    else         state_nxt_s = ST_IDLE;
                end
                ST_SAMPLE: begin
                    if (scnt_r == SCNT_LAST) state_nxt_s = ST_TRIAL;
                    else                     state_nxt_s = ST_SAMPLE;
                end
                ST_TRIAL: state_nxt_s = ST_LATCH;
                ST_LATCH: begin
                    if (idx_r == {IW{1'b0}}) state_nxt_s = ST_DONE;
                    else                     state_nxt_s = ST_TRIAL;
                end
                ST_DONE: begin
                    // A start on the closing DONE edge chains straight into the next sample.
                    if (start_s) state_nxt_s = ST_SAMPLE;
                    else         state_nxt_s = ST_IDLE;
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output decode from registered state only, so no input reaches an output combinationally.
    always_comb begin
        SAMPLE = 1'b0;
        CMPCK  = 1'b0;
        DAC    = {NBIT{1'b0}};
        VALID  = 1'b0;
        BUSY   = 1'b1;
        case (state_r)
            ST_IDLE:   BUSY = 1'b0;
            ST_SAMPLE: SAMPLE = 1'b1;
            ST_TRIAL: begin
                CMPCK = 1'b1;
                DAC   = trial_code(res_r, idx_r);
            end
            ST_LATCH:  DAC = trial_code(res_r, idx_r);
            ST_DONE: begin
                DAC   = res_r;
                VALID = 1'b1;
            end
            default:   BUSY = 1'b0;
        endcase
        DOUT = dout_r;
        OVR  = ovr_r;
    end

    // State register.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) state_r <= ST_IDLE;
        else       state_r <= state_nxt_s;
    end

    // Sample-clock history, tracked regardless of EN.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) cks_q_r <= 1'b0;
        else       cks_q_r <= CKS;
    end

    // Datapath: sample counter, bit index, partial result, published result and overrun flag.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            res_r  <= {NBIT{1'b0}};
            dout_r <= {NBIT{1'b0}};
            idx_r  <= {IW{1'b0}};
            scnt_r <= {SW{1'b0}};
            ovr_r  <= 1'b0;
        end else if (!EN) begin
            res_r  <= {NBIT{1'b0}};
            idx_r  <= {IW{1'b0}};
            scnt_r <= {SW{1'b0}};
            ovr_r  <= 1'b0;
        end else begin
            ovr_r <= ovr_hit_s;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_s) begin
                        res_r  <= {NBIT{1'b0}};
                        scnt_r <= {SW{1'b0}};
                    end
                end
                ST_SAMPLE: begin
                    if (scnt_r == SCNT_LAST) idx_r  <= IDX_TOP;
                    else                     scnt_r <= scnt_r + SW'(1);
                end
                ST_LATCH: begin
                    res_r <= res_upd_s;
                    // The result is published as DONE is entered so DOUT and VALID coincide.
                    if (idx_r == {IW{1'b0}}) dout_r <= res_upd_s;
                    else                     idx_r  <= idx_r - IW'(1);
                end
                default: begin
                    res_r <= res_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar8b_logic.sv
// Scoreboard bench for sar8b_logic: expected results are queued when a CKS edge
// is driven and compared when VALID fires.
module tb_sar8b_logic;

    localparam int NBIT = 8;
    localparam int LAT  = 1 + 2 * NBIT;

    logic            CK = 1'b0;
    logic            RSTN, EN, CKS, CMP;
    logic            SAMPLE, CMPCK, VALID, OVR, BUSY;
    logic [NBIT-1:0] DAC, DOUT;

    logic [1:0] cmp_mode;
    logic [7:0] vin;

    typedef struct {
        logic [7:0] dout;
        int         det;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] trial_q[$];
    logic [7:0] exp_tr[8];

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int valid_cnt = 0;
    int ovr_cnt = 0;
    bit chain_mode = 1'b0;
    bit chain_pend = 1'b0;

    // Comparator: 1 forced, 0 forced, or VIN >= DAC.
    assign CMP = (cmp_mode == 2'd1) ? 1'b1 : (cmp_mode == 2'd2) ? 1'b0 : (vin >= DAC);

    sar8b_logic #(.NBIT(NBIT), .SAMPLE_CYC(1)) dut (
        .CK(CK), .RSTN(RSTN), .EN(EN), .CKS(CKS), .CMP(CMP),
        .SAMPLE(SAMPLE), .CMPCK(CMPCK), .DAC(DAC), .DOUT(DOUT),
        .VALID(VALID), .OVR(OVR), .BUSY(BUSY)
    );

    always #5 CK = ~CK;

    initial forever begin
        @(posedge CK);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference binary search: returns the result and fills exp_tr with the trial codes.
    function automatic logic [7:0] sar_model(input logic [1:0] mode, input logic [7:0] v);
        logic [7:0] r, t;
        logic       c;
        r = 8'h00;
        for (int n = 0; n < 8; n++) begin
            t = r | (8'h80 >> n);
            exp_tr[n] = t;
            c = (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? 1'b0 : (v >= t);
            if (c) r = t;
        end
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CK);
        #1;
    endtask

    task automatic rise_cks(input bit push, input logic [7:0] v);
        exp_t e;
        if (push) begin
            vin    = v;
            e.dout = sar_model(cmp_mode, v);
            e.det  = cyc + 1;
            sb_q.push_back(e);
        end
        CKS = 1'b1;
    endtask

    task automatic wait_valid(input int nb, input int lim);
        int i;
        i = 0;
        while (valid_cnt == nb && i < lim) begin
            tick(1);
            i++;
        end
        if (valid_cnt == nb) chk_eq("valid_timeout", valid_cnt, nb + 1);
    endtask

    task automatic wait_drain(input int lim);
        int i;
        i = 0;
        while (sb_q.size() > 0 && i < lim) begin
            tick(1);
            i++;
        end
        chk_eq("drain", sb_q.size(), 0);
    endtask

    task automatic run_single(input logic [1:0] mode, input logic [7:0] v, input string tag);
        int vb;
        cmp_mode = mode;
        trial_q.delete();
        vb = valid_cnt;
        rise_cks(1'b1, v);
        tick(9);
        CKS = 1'b0;
        wait_valid(vb, 40);
        chk_eq({tag, "_ntrial"}, trial_q.size(), 8);
        if (trial_q.size() == 8) begin
            for (int i = 0; i < 8; i++)
                chk_eq($sformatf("%s_trial%0d", tag, i), trial_q[i], exp_tr[i]);
        end
        tick(9);
    endtask

    // Output monitor: trial capture, overrun count, scoreboard compare on VALID.
    initial forever begin
        exp_t e;
        @(negedge CK);
        if (RSTN) begin
            if (CMPCK) trial_q.push_back(DAC);
            if (OVR) ovr_cnt++;
            if (chain_pend) begin
                chk_eq("chain_sample", SAMPLE, 1'b1);
                chain_pend = 1'b0;
            end
            if (VALID) begin
                valid_cnt++;
                if (sb_q.size() == 0) begin
                    chk_eq("spurious_valid", VALID, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    chk_eq("dout", DOUT, e.dout);
                    chk_eq("latency", cyc - e.det, LAT);
                    if (chain_mode && sb_q.size() > 0) chain_pend = 1'b1;
                end
            end
        end
    end

    logic [7:0] vins18[4] = '{8'h5A, 8'hC3, 8'h01, 8'h7F};
    logic [7:0] vins10[4] = '{8'h10, 8'hFE, 8'h80, 8'h33};

    initial begin
        int         ob, vb;
        logic [7:0] dprev;
        RSTN = 1'b0; EN = 1'b0; CKS = 1'b0; cmp_mode = 2'd1; vin = 8'h00;
        tick(3);
        chk_eq("rst_sample", SAMPLE, 1'b0);
        chk_eq("rst_cmpck", CMPCK, 1'b0);
        chk_eq("rst_dac", DAC, 8'h00);
        chk_eq("rst_dout", DOUT, 8'h00);
        chk_eq("rst_valid", VALID, 1'b0);
        chk_eq("rst_ovr", OVR, 1'b0);
        chk_eq("rst_busy", BUSY, 1'b0);
        #2 RSTN = 1'b1; EN = 1'b1;
        tick(2);

        run_single(2'd1, 8'h00, "ones");
        run_single(2'd2, 8'h00, "zeros");
        run_single(2'd0, 8'h5A, "vin5a");

        // CKS period 18: conversions chain with no idle gap.
        chain_mode = 1'b1;
        cmp_mode = 2'd0;
        ob = ovr_cnt;
        vb = valid_cnt;
        for (int e = 0; e < 4; e++) begin
            rise_cks(1'b1, vins18[e]);
            tick(9);
            CKS = 1'b0;
            tick(9);
        end
        wait_drain(40);
        chk_eq("p18_ovr", ovr_cnt - ob, 0);
        chk_eq("p18_valid", valid_cnt - vb, 4);
        chain_mode = 1'b0;

        // CKS period 10: every other edge lands mid-conversion.
        ob = ovr_cnt;
        vb = valid_cnt;
        for (int e = 0; e < 7; e++) begin
            rise_cks((e % 2) == 0, vins10[e / 2]);
            tick(5);
            CKS = 1'b0;
            tick(5);
        end
        wait_drain(40);
        chk_eq("p10_ovr", ovr_cnt - ob, 3);
        chk_eq("p10_valid", valid_cnt - vb, 4);

        // EN abort during the fourth LATCH.
        tick(4);
        cmp_mode = 2'd0;
        vin = 8'h5A;
        dprev = DOUT;
        vb = valid_cnt;
        rise_cks(1'b0, 8'h5A);
        tick(9);
        chk_eq("latch4_cmpck", CMPCK, 1'b0);
        chk_eq("latch4_busy", BUSY, 1'b1);
        chk_eq("latch4_dac", DAC, 8'h50);
        EN = 1'b0;
        tick(1);
        CKS = 1'b0;
        chk_eq("abort_busy", BUSY, 1'b0);
        chk_eq("abort_dac", DAC, 8'h00);
        chk_eq("abort_cmpck", CMPCK, 1'b0);
        chk_eq("abort_sample", SAMPLE, 1'b0);
        chk_eq("abort_dout", DOUT, dprev);
        tick(25);
        chk_eq("abort_novalid", valid_cnt, vb);
        EN = 1'b1;
        tick(2);
        run_single(2'd0, 8'h3C, "after_en");

        // Asynchronous reset in the middle of a TRIAL cycle.
        vin = 8'hA5;
        rise_cks(1'b0, 8'hA5);
        tick(6);
        chk_eq("pre_rst_cmpck", CMPCK, 1'b1);
        #3 RSTN = 1'b0;
        #1;
        chk_eq("arst_sample", SAMPLE, 1'b0);
        chk_eq("arst_cmpck", CMPCK, 1'b0);
        chk_eq("arst_dac", DAC, 8'h00);
        chk_eq("arst_dout", DOUT, 8'h00);
        chk_eq("arst_valid", VALID, 1'b0);
        chk_eq("arst_ovr", OVR, 1'b0);
        chk_eq("arst_busy", BUSY, 1'b0);
        CKS = 1'b0;
        tick(2);
        #2 RSTN = 1'b1;
        tick(3);
        chk_eq("post_rst_dout", DOUT, 8'h00);
        chk_eq("post_rst_busy", BUSY, 1'b0);
        run_single(2'd0, 8'hA5, "after_rst");

        tick(5);
        chk_eq("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
